// File: rtl/mfp_spi_slave_responder_pkg.sv
// Shared types and default parameter values for the SPI mode-0 target.
package mfp_spi_slave_responder_pkg;

    // Frame state: IDLE while CS is high, ACTIVE while a frame is in progress.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam int          DEF_WIDTH       = 16;
    localparam int          DEF_SYNC_STAGES = 2;
    localparam logic [15:0] DEF_IDLE_WORD   = 16'h0000;

endpackage

// File: rtl/mfp_spi_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous line, followed by a history
// flop that turns level changes into single-cycle rise/fall pulses.
module mfp_spi_sync_edge_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Synchronizer chain plus history flop; preset to the line's idle level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] &  hist_q;

endmodule

// File: rtl/mfp_spi_slave_responder.sv
// SPI mode-0 target: oversamples CS/SCK/SDI on HCLK, shifts out a preloaded
// word MSB first and captures the incoming word.
module mfp_spi_slave_responder
    import mfp_spi_slave_responder_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(DEF_IDLE_WORD)
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             SPI_CS,
    input  logic             SPI_SCK,
    input  logic             SPI_SDI,
    output logic             SPI_SDO,
    output logic             SPI_SDO_OE,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             underrun,
    output logic             frame_error
);

    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic cs_rise, cs_fall, sck_rise, sck_fall;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic sdi_s;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] tx_shift_q;
    logic [WIDTH-2:0] rx_shift_q;
    logic [WIDTH-1:0] tx_buf_q;
    logic             tx_full_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic             underrun_q;
    logic             frame_err_q;
    logic             sdo_oe_q;

    mfp_spi_sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_i  (HCLK),
        .rst_ni (HRESETn),
        .async_i(SPI_CS),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    mfp_spi_sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk_i  (HCLK),
        .rst_ni (HRESETn),
        .async_i(SPI_SCK),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // SDI only needs a level; same depth as SCK so data lines up with the edge pulse.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sdi_sync_q <= '0;
        end else begin
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], SPI_SDI};
        end
    end

    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    // Frame FSM, one-entry tx buffer, shift registers and registered status pulses.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            sdo_oe_q    <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;

            // A load needs an empty buffer, so it can never collide with a consume below.
            if (tx_valid && !tx_full_q) begin
                tx_buf_q  <= tx_data;
                tx_full_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    sdo_oe_q <= 1'b0;
                    if (cs_fall) begin
                        state_q    <= ST_ACTIVE;
                        cnt_q      <= '0;
                        rx_shift_q <= '0;
                        sdo_oe_q   <= 1'b1;
                        if (tx_full_q) begin
                            tx_shift_q <= tx_buf_q;
                            tx_full_q  <= 1'b0;
                        end else begin
                            tx_shift_q <= IDLE_WORD;
                            underrun_q <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        // End of frame wins over any SCK edge seen in the same cycle.
                        state_q    <= ST_IDLE;
                        sdo_oe_q   <= 1'b0;
                        tx_shift_q <= '0;
                        if (cnt_q != CNT_FULL) begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        if (sck_rise && (cnt_q != CNT_FULL)) begin
                            rx_shift_q <= {rx_shift_q[WIDTH-3:0], sdi_s};
                            cnt_q      <= cnt_q + CNT_ONE;
                            if (cnt_q == CNT_LAST) begin
                                rx_data_q  <= {rx_shift_q, sdi_s};
                                rx_valid_q <= 1'b1;
                            end
                        end
                        if (sck_fall) begin
                            if (cnt_q != CNT_FULL) begin
                                tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
                            end else begin
                                tx_shift_q <= '0;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The shift register is cleared outside a frame, so its MSB is a clean SDO.
    assign SPI_SDO     = tx_shift_q[WIDTH-1];
    assign SPI_SDO_OE  = sdo_oe_q;
    assign tx_ready    = ~tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign underrun    = underrun_q;
    assign frame_error = frame_err_q;

endmodule

// File: tb/tb_mfp_spi_slave_responder.sv
// Self-checking bench: table of SPI frames plus hand-written sequences for
// double loading and reset mid-frame; received words go through a scoreboard.
module tb_mfp_spi_slave_responder;

    logic        HCLK;
    logic        HRESETn;
    logic        SPI_CS;
    logic        SPI_SCK;
    logic        SPI_SDI;
    logic        SPI_SDO;
    logic        SPI_SDO_OE;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        underrun;
    logic        frame_error;

    mfp_spi_slave_responder #(.WIDTH(16), .SYNC_STAGES(2), .IDLE_WORD(16'h0000)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .SPI_CS     (SPI_CS),
        .SPI_SCK    (SPI_SCK),
        .SPI_SDI    (SPI_SDI),
        .SPI_SDO    (SPI_SDO),
        .SPI_SDO_OE (SPI_SDO_OE),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .underrun   (underrun),
        .frame_error(frame_error)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    typedef struct {
        logic [15:0] load_word;
        bit          do_load;
        logic [15:0] sdi_word;
        int          nbits;
        logic [15:0] exp_sdo;
        int          exp_rxv;
        int          exp_und;
        int          exp_ferr;
    } vec_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          obs_rd = 0;
    int          rxv_tot = 0;
    int          und_tot = 0;
    int          ferr_tot = 0;
    logic [15:0] last_rx;

    // Monitor: record every rx word and count status pulses.
    always @(negedge HCLK) begin
        if (rx_valid) begin
            obs_q.push_back(rx_data);
            rxv_tot++;
        end
        if (underrun)    und_tot++;
        if (frame_error) ferr_tot++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every word the monitor saw against the expected queue.
    task automatic drain();
        logic [15:0] w;
        while (obs_rd < obs_q.size()) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected_rx: got %0h expected none", obs_q[obs_rd]);
            end else begin
                w = exp_q.pop_front();
                check("sb_rx_data", {16'h0, obs_q[obs_rd]}, {16'h0, w});
            end
            obs_rd++;
        end
    endtask

    task automatic load(input logic [15:0] w);
        @(negedge HCLK);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge HCLK);
        tx_valid = 1'b0;
    endtask

    // SPI mode-0 master at HCLK/8; SDO sampled just before each SCK rise.
    task automatic run_frame(input logic [15:0] sdi_word, input int nbits,
                             input bit mid_load, input logic [15:0] mid_word,
                             output logic [15:0] sdo_cap, output bit tail_zero,
                             output bit oe_ok);
        sdo_cap   = '0;
        tail_zero = 1'b1;
        oe_ok     = 1'b1;
        @(negedge HCLK);
        SPI_CS  = 1'b0;
        SPI_SDI = sdi_word[15];
        repeat (6) @(negedge HCLK);
        for (int i = 0; i < nbits; i++) begin
            if (SPI_SDO_OE !== 1'b1) oe_ok = 1'b0;
            if (i < 16) sdo_cap = {sdo_cap[14:0], SPI_SDO};
            else if (SPI_SDO !== 1'b0) tail_zero = 1'b0;
            SPI_SCK = 1'b1;
            if (mid_load && i == 4) begin
                tx_data  = mid_word;
                tx_valid = 1'b1;
            end
            @(negedge HCLK);
            tx_valid = 1'b0;
            repeat (3) @(negedge HCLK);
            SPI_SCK = 1'b0;
            if (i + 1 < 16) SPI_SDI = sdi_word[14 - i];
            else            SPI_SDI = 1'b1;
            repeat (4) @(negedge HCLK);
        end
        SPI_CS  = 1'b1;
        SPI_SDI = 1'b0;
        repeat (10) @(negedge HCLK);
    endtask

    // Run one frame and check all of its observable results.
    task automatic frame_and_check(input string tag, input logic [15:0] sdi_word, input int nbits,
                                   input bit mid_load, input logic [15:0] mid_word,
                                   input logic [15:0] exp_sdo, input int exp_rxv,
                                   input int exp_und, input int exp_ferr, input logic exp_ready);
        logic [15:0] cap;
        bit          tz;
        bit          oe;
        int          rxv0, und0, ferr0;
        rxv0  = rxv_tot;
        und0  = und_tot;
        ferr0 = ferr_tot;
        if (nbits >= 16) begin
            exp_q.push_back(sdi_word);
            last_rx = sdi_word;
        end
        run_frame(sdi_word, nbits, mid_load, mid_word, cap, tz, oe);
        check({tag, "_sdo"},      {16'h0, cap}, {16'h0, exp_sdo});
        check({tag, "_oe"},       {31'h0, oe}, 32'd1);
        if (nbits > 16) check({tag, "_tail_zero"}, {31'h0, tz}, 32'd1);
        check({tag, "_rx_valid_cnt"}, rxv_tot - rxv0, exp_rxv);
        check({tag, "_underrun_cnt"}, und_tot - und0, exp_und);
        check({tag, "_frame_err_cnt"}, ferr_tot - ferr0, exp_ferr);
        check({tag, "_tx_ready"}, {31'h0, tx_ready}, {31'h0, exp_ready});
        check({tag, "_rx_data"},  {16'h0, rx_data}, {16'h0, last_rx});
        check({tag, "_oe_after"}, {31'h0, SPI_SDO_OE}, 32'd0);
        drain();
        $display("frame %s: sdo=%h rx_data=%h rxv=%0d und=%0d ferr=%0d",
                 tag, cap, rx_data, rxv_tot - rxv0, und_tot - und0, ferr_tot - ferr0);
    endtask

    vec_t vecs[5];

    initial begin
        HRESETn  = 1'b0;
        SPI_CS   = 1'b1;
        SPI_SCK  = 1'b0;
        SPI_SDI  = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        last_rx  = '0;

        vecs[0] = '{16'hA5C3, 1'b1, 16'h3C5A, 16, 16'hA5C3, 1, 0, 0};
        vecs[1] = '{16'h0000, 1'b0, 16'h1357, 16, 16'h0000, 1, 1, 0};
        vecs[2] = '{16'hFFFF, 1'b1, 16'h0F0F,  9, 16'h01FF, 0, 0, 1};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000, 16, 16'h0000, 1, 1, 0};
        vecs[4] = '{16'h8001, 1'b1, 16'hBEEF, 20, 16'h8001, 1, 0, 0};

        // Reset state.
        repeat (3) @(negedge HCLK);
        check("rst_sdo",       {31'h0, SPI_SDO}, 32'd0);
        check("rst_oe",        {31'h0, SPI_SDO_OE}, 32'd0);
        check("rst_tx_ready",  {31'h0, tx_ready}, 32'd1);
        check("rst_rx_data",   {16'h0, rx_data}, 32'd0);
        check("rst_rx_valid",  {31'h0, rx_valid}, 32'd0);
        check("rst_underrun",  {31'h0, underrun}, 32'd0);
        check("rst_frame_err", {31'h0, frame_error}, 32'd0);
        HRESETn = 1'b1;
        repeat (4) @(negedge HCLK);

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_load) begin
                load(vecs[v].load_word);
                check($sformatf("v%0d_tx_ready_loaded", v), {31'h0, tx_ready}, 32'd0);
            end
            frame_and_check($sformatf("v%0d", v), vecs[v].sdi_word, vecs[v].nbits, 1'b0, 16'h0,
                            vecs[v].exp_sdo, vecs[v].exp_rxv, vecs[v].exp_und,
                            vecs[v].exp_ferr, 1'b1);
        end

        // Second word loaded during a frame is held for the following frame.
        load(16'h1234);
        frame_and_check("dbl1", 16'h0001, 16, 1'b1, 16'h5678, 16'h1234, 1, 0, 0, 1'b0);
        frame_and_check("dbl2", 16'h8000, 16, 1'b0, 16'h0000, 16'h5678, 1, 0, 0, 1'b1);

        // Reset in the middle of a frame drops OE at once and loses the buffered word.
        load(16'hA5A5);
        @(negedge HCLK);
        SPI_CS = 1'b0;
        repeat (6) @(negedge HCLK);
        for (int i = 0; i < 7; i++) begin
            SPI_SCK = 1'b1;
            repeat (4) @(negedge HCLK);
            SPI_SCK = 1'b0;
            repeat (4) @(negedge HCLK);
        end
        load(16'h5A5A);
        check("mid_tx_ready", {31'h0, tx_ready}, 32'd0);
        check("mid_oe",       {31'h0, SPI_SDO_OE}, 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        check("arst_oe",  {31'h0, SPI_SDO_OE}, 32'd0);
        check("arst_sdo", {31'h0, SPI_SDO}, 32'd0);
        SPI_CS = 1'b1;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("post_rst_tx_ready", {31'h0, tx_ready}, 32'd1);
        check("post_rst_rx_data",  {16'h0, rx_data}, 32'd0);
        check("post_rst_rx_valid", {31'h0, rx_valid}, 32'd0);
        last_rx = 16'h0000;
        repeat (4) @(negedge HCLK);
        frame_and_check("post_rst", 16'hC0DE, 16, 1'b0, 16'h0000, 16'h0000, 1, 1, 0, 1'b1);

        check("sb_leftover", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
